// File: rtl/alu_mc.sv
// Multi-cycle ALU for the EX stage: single-cycle logic/arith ops plus
// an iterative shift-add multiply, with valid/ready on both sides.
module alu_mc #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t state;
  state_t state_nx;

  logic accept;
  logic is_mul;
  logic mul_done;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   mplier;
  logic [SH_W-1:0]    count;

  logic             sub;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_r;
  logic             alu_v;
  logic             alu_c;

  // handshake decode and FSM next state
  always_comb begin
    in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    is_mul   = MUL_EN && (cntrl == OP_MUL);
    mul_done = (state == S_MUL) && (count == SH_W'(WIDTH - 1));
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept && is_mul) state_nx = S_MUL;
      S_MUL:   if (mul_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // single-cycle datapath; SUB is A + ~B + 1 through the shared adder
  always_comb begin
    sub   = (cntrl == OP_SUB);
    opb   = sub ? ~B : B;
    sum   = {1'b0, A} + {1'b0, opb} + {{WIDTH{1'b0}}, sub};
    alu_r = B;
    alu_v = 1'b0;
    alu_c = 1'b0;
    unique case (cntrl)
      OP_ADD, OP_SUB: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (A[MSB] == opb[MSB]) && (sum[MSB] != A[MSB]);
      end
      OP_AND:  alu_r = A & B;
      OP_OR:   alu_r = A | B;
      OP_XOR:  alu_r = A ^ B;
      OP_SLL:  alu_r = A << B[SH_W-1:0];
      OP_PASS: alu_r = B;
      default: alu_r = B;
    endcase
  end

  // next partial product: add the shifted multiplicand if this bit is set
  always_comb begin
    acc_nx = acc + (mplier[0] ? mcand : '0);
  end

  // multiplier iteration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (accept && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
      count  <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  // registered result, flags and output valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= acc_nx[WIDTH-1:0];
      negative  <= acc_nx[MSB];
      zero      <= (acc_nx[WIDTH-1:0] == '0);
      overflow  <= |acc_nx[2*WIDTH-1:WIDTH];
      carry_out <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      result    <= alu_r;
      negative  <= alu_r[MSB];
      zero      <= (alu_r == '0);
      overflow  <= alu_v;
      carry_out <= alu_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: hand vectors, handshake corner sequences and
// random ops against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   cntrl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         negative;
  logic         zero;
  logic         overflow;
  logic         carry_out;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cntrl     (cntrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {negative, zero, overflow, carry_out};
  endfunction

  // reference: plain integer arithmetic on wide values
  function automatic void model(input logic [2:0] op,
                                input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] r,
                                output logic [3:0] f);
    logic [2*W-1:0] p;
    logic [W:0] s;
    logic signed [W+1:0] ws;
    logic v, c;
    v = 1'b0;
    c = 1'b0;
    r = b;
    case (op)
      3'd1: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = p[W-1:0];
        v = (p[2*W-1:W] != 0);
      end
      3'd2: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        c  = s[W];
        ws = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
        v  = (ws != $signed({{2{r[W-1]}}, r}));
      end
      3'd3: begin
        r  = a - b;
        c  = (a >= b);
        ws = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
        v  = (ws != $signed({{2{r[W-1]}}, r}));
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      3'd7: r = a << (b % W);
      default: r = b;
    endcase
    f = {r[W-1], (r == 0), v, c};
  endfunction

  // issue one op with out_ready=1 and wait for its result
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] r,
                        output logic [3:0] f, output int lat,
                        output int leak);
    int t;
    t = 0;
    leak = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=0 want=1");
    end
    in_valid = 1'b1;
    cntrl = op;
    A = a;
    B = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) leak++;
    end while (!out_valid && lat < 200);
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout got=0 want=1");
    end
    r = result;
    f = flags();
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] er;
    logic [3:0]   ef;
  } vec_t;

  vec_t vt[13];

  logic [2:0]   sop[4];
  logic [W-1:0] sa[4];
  logic [W-1:0] sb[4];
  logic [W-1:0] sr[4];

  initial begin
    logic [W-1:0] r, mr;
    logic [3:0]   f, mf;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    int lat, leak, seen;

    vt[0]  = '{3'd2, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000,
               64'h8000_0000_0000_0000, 4'b1010};
    vt[1]  = '{3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
               64'hFFFF_FFFF_FFFF_FFFE, 4'b1001};
    vt[2]  = '{3'd3, 64'd1, 64'd1, 64'd0, 4'b0101};
    vt[3]  = '{3'd1, 64'd3, 64'd5, 64'd15, 4'b0000};
    vt[4]  = '{3'd1, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 4'b0110};
    vt[5]  = '{3'd7, 64'd1, 64'h43, 64'd8, 4'b0000};
    vt[6]  = '{3'd0, 64'h1234, 64'h8000_0000_0000_0001,
               64'h8000_0000_0000_0001, 4'b1000};
    vt[7]  = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0101};
    vt[8]  = '{3'd4, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000};
    vt[9]  = '{3'd5, 64'hF0F0, 64'h0F0F, 64'hFFFF, 4'b0000};
    vt[10] = '{3'd6, 64'hABCD, 64'hABCD, 64'd0, 4'b0100};
    vt[11] = '{3'd3, 64'h8000_0000_0000_0000, 64'd1,
               64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vt[12] = '{3'd7, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 4'b1000};

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    cntrl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", 64'(flags()), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 13; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, r, f, lat, leak);
      chk($sformatf("vec%0d_result", i), r, vt[i].er);
      chk($sformatf("vec%0d_flags", i), 64'(f), 64'(vt[i].ef));
      chk($sformatf("vec%0d_latency", i), 64'(lat),
          (vt[i].op == 3'd1) ? 64'(W + 1) : 64'd1);
      if (vt[i].op == 3'd1)
        chk($sformatf("vec%0d_busy_ready", i), 64'(leak), 64'd0);
    end

    // back-to-back stream, one result per cycle
    sop[0] = 3'd6; sa[0] = 64'hFF00; sb[0] = 64'h0FF0;
    sop[1] = 3'd7; sa[1] = 64'd1;    sb[1] = 64'h43;
    sop[2] = 3'd6; sa[2] = 64'h5555; sb[2] = 64'hFFFF;
    sop[3] = 3'd7; sa[3] = 64'h3;    sb[3] = 64'd4;
    for (int i = 0; i < 4; i++) model(sop[i], sa[i], sb[i], sr[i], f);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    cntrl = sop[0];
    A = sa[0];
    B = sb[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("stream%0d_result", i), result, sr[i]);
      if (i < 3) begin
        cntrl = sop[i+1];
        A = sa[i+1];
        B = sb[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("stream_drain", 64'(out_valid), 64'd0);

    // backpressure: result holds, no accept, then pop+accept together
    out_ready = 1'b0;
    in_valid = 1'b1;
    cntrl = 3'd2;
    A = 64'd5;
    B = 64'd7;
    @(negedge clk);
    chk("bp_first", result, 64'd12);
    A = 64'd1;
    B = 64'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), result, 64'd12);
      chk($sformatf("bp_valid%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp_ready%0d", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_ready_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_replace", result, 64'd3);
    chk("bp_replace_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("bp_pop", 64'(out_valid), 64'd0);

    // reset in the middle of a multiply
    in_valid = 1'b1;
    cntrl = 3'd1;
    A = 64'd7;
    B = 64'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("mrst_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < W + 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mrst_no_output", 64'(seen), 64'd0);
    run_op(3'd2, 64'd1, 64'd1, r, f, lat, leak);
    chk("mrst_add", r, 64'd2);

    // random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 4 == 1) b = 64'($urandom_range(0, 300));
      if (i % 5 == 2) a = b;
      run_op(op, a, b, r, f, lat, leak);
      model(op, a, b, mr, mf);
      chk($sformatf("rnd%0d_op%0d_result", i, op), r, mr);
      chk($sformatf("rnd%0d_op%0d_flags", i, op), 64'(f), 64'(mf));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
